// File: rtl/core_mem_arbiter_pkg.sv
// Shared types for the core-side RAM port arbiter: requester ids and arbiter states.
package core_mem_arbiter_pkg;

    localparam int NumReq = 2;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    typedef enum logic {
        ARB_RR   = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/core_mem_arbiter_rr.sv
// Two-way round-robin selector with a data-side lock; purely combinational,
// the last-granted pointer is owned by the parent.
module rr_arbiter2
    import core_mem_arbiter_pkg::*;
(
    input  logic [NumReq-1:0] req,
    input  req_id_e           last,
    input  logic              lock,
    output logic [NumReq-1:0] sel
);

    always_comb begin
        // NOTE: default every combinational output first so no path infers a latch.
        sel = '0;
        if (lock) begin
            sel[REQ_D] = req[REQ_D];
        end else if (&req) begin
            if (last == REQ_I) sel[REQ_D] = 1'b1;
            else               sel[REQ_I] = 1'b1;
        end else begin
            sel = req;
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares the core-side RAM port between instruction fetch and load/store, steers
// 1-cycle read data back to the issuer and counts contention cycles.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int ByteLength = 8,
    parameter int CntWidth   = 32
) (
    input  logic                            core_clk_i,
    input  logic                            rstn_i,

    input  logic [AddrWidth-1:0]            i_addr_i,
    input  logic                            i_rden_i,
    output logic                            i_gnt_o,
    output logic [DataWidth-1:0]            i_rdata_o,
    output logic                            i_rvalid_o,

    input  logic [AddrWidth-1:0]            d_addr_i,
    input  logic                            d_wren_i,
    input  logic [DataWidth-1:0]            d_wdata_i,
    input  logic [DataWidth/ByteLength-1:0] d_wmask_i,
    input  logic                            d_rden_i,
    input  logic                            d_lock_i,
    output logic                            d_gnt_o,
    output logic [DataWidth-1:0]            d_rdata_o,
    output logic                            d_rvalid_o,

    output logic [AddrWidth-1:0]            m_addr_o,
    output logic                            m_wren_o,
    output logic [DataWidth-1:0]            m_wdata_o,
    output logic [DataWidth/ByteLength-1:0] m_wmask_o,
    output logic                            m_rden_o,
    input  logic [DataWidth-1:0]            m_rdata_i,
    input  logic                            m_hit_i,

    output logic [CntWidth-1:0]             conflict_cnt_o
);

    arb_state_e          state_q, state_d;
    req_id_e             last_q;
    req_id_e             rsel_q;
    logic                rpend_q;
    logic [CntWidth-1:0] cnt_q;

    logic [NumReq-1:0]   req;
    logic [NumReq-1:0]   arb_sel;
    logic [NumReq-1:0]   sel;
    logic                d_read_gnt;

    assign req[REQ_I] = i_rden_i;
    assign req[REQ_D] = d_rden_i | d_wren_i;

    rr_arbiter2 u_rr (
        .req  (req),
        .last (last_q),
        .lock (state_q == ARB_LOCK),
        .sel  (arb_sel)
    );

    // Reset also masks the combinational path so nothing reaches the RAM while held.
    assign sel = rstn_i ? arb_sel : '0;

    assign i_gnt_o    = sel[REQ_I] & m_hit_i;
    assign d_gnt_o    = sel[REQ_D] & m_hit_i;
    assign d_read_gnt = d_gnt_o & d_rden_i & ~d_wren_i;

    always_comb begin
        m_addr_o  = '0;
        m_wren_o  = 1'b0;
        m_wdata_o = '0;
        m_wmask_o = '0;
        m_rden_o  = 1'b0;
        if (sel[REQ_D]) begin
            // A store wins over a simultaneous (illegal) load on the RAM port.
            m_addr_o  = d_addr_i;
            m_wren_o  = d_wren_i;
            m_wdata_o = d_wdata_i;
            m_wmask_o = d_wren_i ? d_wmask_i : '0;
            m_rden_o  = d_rden_i & ~d_wren_i;
        end else if (sel[REQ_I]) begin
            m_addr_o  = i_addr_i;
            m_rden_o  = i_rden_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_RR:   if (d_gnt_o &&  d_lock_i) state_d = ARB_LOCK;
            ARB_LOCK: if (d_gnt_o && !d_lock_i) state_d = ARB_RR;
            default:  state_d = ARB_RR;
        endcase
    end

    always_ff @(posedge core_clk_i or negedge rstn_i) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstn_i) begin
            state_q <= ARB_RR;
            last_q  <= REQ_I;
            rsel_q  <= REQ_I;
            rpend_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (i_gnt_o)      last_q <= REQ_I;
            else if (d_gnt_o) last_q <= REQ_D;

            rpend_q <= i_gnt_o | d_read_gnt;
            if (i_gnt_o)         rsel_q <= REQ_I;
            else if (d_read_gnt) rsel_q <= REQ_D;

            if (req[REQ_I] && req[REQ_D] && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign i_rdata_o      = m_rdata_i;
    assign d_rdata_o      = m_rdata_i;
    assign i_rvalid_o     = rpend_q && (rsel_q == REQ_I);
    assign d_rvalid_o     = rpend_q && (rsel_q == REQ_D);
    assign conflict_cnt_o = cnt_q;

    no_d_read_and_write: assert property (
        @(posedge core_clk_i) disable iff (!rstn_i) !(d_rden_i && d_wren_i));

    grants_onehot: assert property (
        @(posedge core_clk_i) disable iff (!rstn_i) !(i_gnt_o && d_gnt_o));

endmodule
